fetch_pc_unit: RTL

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with BOOT/RUN/HALTED control and instruction field decode.
// Optional retired-instruction counter is enabled by defining FETCH_RETIRED_CNT_EN.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_sel_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            halt_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [1:0]      pc_bits_o,
  output logic [1:0]      T_o,
  output logic [2:0]      OPC_o,
  output logic [4:0]      ra_o,
  output logic [4:0]      rb_o,
  output logic [4:0]      rc_o,
  output logic [16:0]     imm_o,
  output logic            instr_valid_o,
  output logic [1:0]      state_o,
  output logic [XLEN-1:0] retired_cnt_o
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;

  always_comb begin
    next_pc = pc;
    case (pc_sel_i)
      2'd0:    next_pc = pc + 32'd4;
      2'd1:    next_pc = pc + alu_result_i;
      2'd2:    next_pc = alu_result_i;
      default: next_pc = pc;
    endcase
  end

  // Halt wins over pc_sel_i: the PC freezes on the same edge the FSM leaves RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_VECTOR;
      state <= BOOT;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN: begin
          if (halt_i) begin
            state <= HALTED;
          end else begin
            pc <= next_pc;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= HALTED;
      endcase
    end
  end

  assign pc_o          = pc;
  assign pc_plus4_o    = pc + 32'd4;
  assign pc_bits_o     = pc[1:0];
  assign state_o       = state;
  assign instr_valid_o = (state == RUN);

  assign T_o   = instr_valid_o ? instr_i[31:30] : 2'd0;
  assign OPC_o = instr_valid_o ? instr_i[29:27] : 3'd0;
  assign ra_o  = instr_valid_o ? instr_i[26:22] : 5'd0;
  assign rb_o  = instr_valid_o ? instr_i[21:17] : 5'd0;
  assign rc_o  = instr_valid_o ? instr_i[16:12] : 5'd0;
  assign imm_o = instr_valid_o ? instr_i[16:0]  : 17'd0;

`ifdef FETCH_RETIRED_CNT_EN
  logic [XLEN-1:0] retired_cnt;

  // Saturates rather than wrapping so a long run never reports a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (state == RUN && !halt_i && retired_cnt != '1) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign retired_cnt_o = retired_cnt;
`else
  assign retired_cnt_o = '0;
`endif

endmodule
